serial_add_ctrl: RTL and testbench

- Bit-serial adder controller: time-multiplexes one Full_Adder cell across the bits of a WIDTH-bit addition, one bit per clock, LSB first.
- Owns the operand shift registers, the carry flop, the bit counter and the start/done handshake.
- Sits between a requesting datapath and the gate-level adder cell, trading latency for area.

---
 rtl/ser_add_pkg.sv | 13 +
 rtl/serial_add_ctrl_full_adder.sv | 17 +
 rtl/serial_add_ctrl.sv | 101 ++++++++++
 tb/tb_serial_add_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings
// and the default operand width.
package ser_add_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Gate-level 1-bit full adder cell; the controller time-multiplexes one
// instance of it across every bit of the addition.
module Full_Adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half;

   assign half = a ^ b;
   assign s    = half ^ cin;
   assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one Full_Adder cell, one bit per clock, LSB
// first, with a start/done handshake around a WIDTH-cycle RUN phase.
module serial_add_ctrl
   import ser_add_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] psum;
   logic [WIDTH-1:0] psum_next;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic             msb_cin;
   logic             s_cell;
   logic             c_cell;
   logic             capture;
   logic             last_bit;

   Full_Adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_q),
      .s    (s_cell),
      .cout (c_cell)
   );

   assign capture   = start && (state == S_IDLE || state == S_DONE);
   assign last_bit  = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
   assign psum_next = {s_cell, psum[WIDTH-1:1]};
   assign busy      = (state == S_RUN);
   assign done      = (state == S_DONE);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // NOTE: next state is defaulted before the case so no path can infer a latch.
   always_comb begin
      state_next = S_IDLE;
      case (state)
         S_IDLE:  state_next = start ? S_RUN : S_IDLE;
         S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
         S_DONE:  state_next = start ? S_RUN : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         psum    <= '0;
         cnt     <= '0;
         carry_q <= 1'b0;
         msb_cin <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (capture) begin
         a_sh    <= a;
         b_sh    <= b;
         psum    <= '0;
         cnt     <= '0;
         carry_q <= cin;
      end else if (state == S_RUN) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         psum    <= psum_next;
         carry_q <= c_cell;
         cnt     <= cnt + CW'(1);
         // The carry produced by bit WIDTH-2 is the carry into the MSB.
         if (cnt == CW'(WIDTH - 2)) msb_cin <= c_cell;
         if (last_bit) begin
            sum  <= psum_next;
            cout <= c_cell;
            ovf  <= msb_cin ^ c_cell;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random self-checking bench for serial_add_ctrl at WIDTH=8
// and WIDTH=2, comparing against an arithmetic reference a+b+cin.
module tb_serial_add_ctrl;
   import ser_add_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start, cin, busy, done, cout, ovf;
   logic [7:0] a, b, sum;

   logic       start2, cin2, busy2, done2, cout2, ovf2;
   logic [1:0] a2, b2, sum2;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_sum8 = 8'h00;
   logic [1:0] exp_sum2 = 2'b00;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input string tag);
      logic [8:0] full;
      logic       eovf;
      int         lat;
      int         busy_n;
      full = {1'b0, ia} + {1'b0, ib} + 9'(ic);
      eovf = (ia[7] == ib[7]) && (full[7] != ia[7]);
      a = ia; b = ib; cin = ic; start = 1'b1;
      step();
      start = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
      lat = 0; busy_n = 0;
      while (!done && lat < 20) begin
         if (busy) busy_n++;
         if (lat == 4) check({tag, "_sum_hold"}, sum, exp_sum8);
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, 8);
      check({tag, "_busy_cycles"}, busy_n, 8);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_sum"}, sum, full[7:0]);
      check({tag, "_cout"}, cout, full[8]);
      check({tag, "_ovf"}, ovf, eovf);
      exp_sum8 = full[7:0];
   endtask

   task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ic, input string tag);
      logic [2:0] full;
      logic       eovf;
      int         lat;
      full = {1'b0, ia} + {1'b0, ib} + 3'(ic);
      eovf = (ia[1] == ib[1]) && (full[1] != ia[1]);
      a2 = ia; b2 = ib; cin2 = ic; start2 = 1'b1;
      step();
      start2 = 1'b0; a2 = ~ia; b2 = ~ib; cin2 = ~ic;
      lat = 0;
      while (!done2 && lat < 20) begin
         if (lat == 1) check({tag, "_sum_hold"}, sum2, exp_sum2);
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, 2);
      check({tag, "_sum"}, sum2, full[1:0]);
      check({tag, "_cout"}, cout2, full[2]);
      check({tag, "_ovf"}, ovf2, eovf);
      exp_sum2 = full[1:0];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [7:0] bb_a [3];
      logic [7:0] bb_b [3];
      logic       bb_c [3];
      logic [8:0] full;
      logic [7:0] ra, rb;
      logic [1:0] ra2, rb2;
      int         seen;

      bb_a = '{8'h12, 8'h20, 8'hF0};
      bb_b = '{8'h34, 8'h05, 8'hF0};
      bb_c = '{1'b0, 1'b1, 1'b1};

      start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sum", sum, 8'h00);
      check("rst_cout", cout, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst2_busy", busy2, 1'b0);
      check("rst2_sum", sum2, 2'b00);
      rst_n = 1'b1;
      step();
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);

      op8(8'h5A, 8'h3C, 1'b0, "t5a_3c");
      step();
      check("t5a_3c_done_pulse", done, 1'b0);
      check("t5a_3c_idle_busy", busy, 1'b0);
      check("t5a_3c_sum_after", sum, 8'h96);

      op8(8'hFF, 8'h01, 1'b0, "tff_01");
      op8(8'h7F, 8'h00, 1'b1, "t7f_00_c1");
      step();

      // Start held high throughout; operands churn every RUN cycle.
      for (int i = 0; i < 3; i++) begin
         a = bb_a[i]; b = bb_b[i]; cin = bb_c[i]; start = 1'b1;
         full = {1'b0, bb_a[i]} + {1'b0, bb_b[i]} + 9'(bb_c[i]);
         step();
         check("bb_accept_busy", busy, 1'b1);
         check("bb_accept_done", done, 1'b0);
         for (int k = 1; k <= 8; k++) begin
            a = 8'($urandom()); b = 8'($urandom()); cin = 1'($urandom());
            step();
            if (k < 8) begin
               check("bb_run_done", done, 1'b0);
            end else begin
               check("bb_done", done, 1'b1);
               check("bb_sum", sum, full[7:0]);
               check("bb_cout", cout, full[8]);
               check("bb_ovf", ovf, (bb_a[i][7] == bb_b[i][7]) && (full[7] != bb_a[i][7]));
            end
         end
         exp_sum8 = full[7:0];
      end
      start = 1'b0;
      step();
      check("bb_end_done", done, 1'b0);
      check("bb_end_busy", busy, 1'b0);

      // Reset lands on the fourth RUN cycle of 0x11+0x22.
      a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      check("abort_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_sum", sum, 8'h00);
      check("abort_cout", cout, 1'b0);
      check("abort_ovf", ovf, 1'b0);
      exp_sum8 = 8'h00;
      exp_sum2 = 2'b00;
      seen = 0;
      repeat (12) begin
         step();
         if (done || busy) seen++;
      end
      check("abort_no_done", seen, 0);
      op8(8'h11, 8'h22, 1'b0, "t11_22");
      check("t11_22_sum_val", sum, 8'h33);

      op8(8'h0F, 8'h01, 1'b0, "t0f_01");
      seen = 0;
      repeat (20) begin
         step();
         if (done) seen++;
         check("hold_sum", sum, 8'h10);
      end
      check("hold_no_done", seen, 0);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom()); rb = 8'($urandom());
         op8(ra, rb, 1'($urandom()), "rnd8");
      end

      op2(2'b01, 2'b01, 1'b0, "w2_01_01");
      op2(2'b11, 2'b01, 1'b0, "w2_11_01");
      for (int i = 0; i < 1000; i++) begin
         ra2 = 2'($urandom()); rb2 = 2'($urandom());
         op2(ra2, rb2, 1'($urandom()), "rnd2");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
